alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU for the processor datapath with valid/ready handshakes on input and output.
//  Adds status flags, illegal-op reporting and an optional iterative multiplier.
//  Sits between register-file read and write-back; the control unit drives ops, write-back consumes results.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=4)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand/op beat valid
//  in_ready   out  1      block accepts beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_op      in   4      opcode (alu_pkg::alu_op_e)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result
//  out_q      out  WIDTH  result
//  out_flags  out  4      {V,C,N,Z}
//  out_err    out  1      illegal opcode for this beat
// BEHAVIOUR
//  Reset: out_valid=0, out_q=0, out_flags=0, out_err=0, FSM=IDLE; takes effect immediately (async).
//  Opcodes: 0 ZERO, 1 ADD, 2 SUB (A-B), 3 PASSA, 4 XOR, 5 OR, 6 AND, 7 INC (A+1), 8 MUL; 9-15 illegal.
//  Arithmetic is modulo 2^WIDTH; MUL returns the low WIDTH bits of A*B.
//  Flags:
//   - Z = (q==0); N = q[WIDTH-1]
//   - C = carry-out for ADD/INC, borrow (A<B unsigned) for SUB, else 0
//   - V = signed overflow for ADD/SUB/INC, else 0
//  Illegal op: q=0, flags=0, out_err=1; still produces one output beat.
//  Handshake: input beat accepted when in_valid&&in_ready.
//  Output beat consumed when out_valid&&out_ready; out_q/out_flags/out_err stay stable while out_valid&&!out_ready.
//  in_ready = (state==IDLE) && (!out_valid || out_ready); combinational, with no dependence on in_valid.
//  Single-cycle ops: result registered, out_valid asserts the cycle after acceptance (latency 1).
//   - Full throughput of 1 beat/clk when out_ready is held high.
//  FSM IDLE -> MUL_BUSY on accepted MUL -> MUL_DONE after WIDTH iterations -> IDLE when the result is loaded.
//   - Output register loads in MUL_DONE only if !out_valid||out_ready; otherwise the FSM stays in MUL_DONE.
//   - in_ready=0 in MUL_BUSY and MUL_DONE.
//  MUL latency is WIDTH+1 cycles from acceptance to out_valid.
//  Simultaneous consume of the old result and accept of a new beat in the same cycle is legal; the new result replaces the old one.
//  Reset mid-MUL aborts the operation; no partial result is ever emitted.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - MUL (op 8) is implemented through the iterative sub-module and the FSM above.
//  ALU_MUL_EN undefined:
//   - op 8 is treated as illegal (q=0, out_err=1, latency 1).
//   - FSM reduces to IDLE only; no multiplier logic is present.
// STRUCTURE
//  Package alu_pkg:
//   - alu_op_e (4-bit enum)
//   - alu_flags_t packed struct {v,c,n,z}
//   - localparam OP_W=4
//   - fsm state enum {IDLE, MUL_BUSY, MUL_DONE}
//  Sub-module alu_mul_seq: shift-add multiplier, WIDTH iterations, start/done pulse interface.
//   - Only instantiated under ALU_MUL_EN.
// TESTING (WIDTH=16)
//  1. ADD A=16'h7FFF B=16'h0001, out_ready=1 -> next cycle q=16'h8000, flags V=1 C=0 N=1 Z=0, err=0.
//  2. SUB A=16'h0003 B=16'h0005 -> q=16'hFFFE, C=1 (borrow), N=1.
//     INC A=16'hFFFF -> q=16'h0000, Z=1, C=1.
//  3. Backpressure: issue AND 16'hF0F0&16'h0FF0 with out_ready=0 for 5 clks.
//     -> q=16'h00F0 held stable, in_ready=0.
//     Raise out_ready with a new XOR beat in the same cycle -> XOR result follows next cycle, no beat lost.
//  4. Back-to-back ops 1..7 with out_ready=1 -> 7 results on 7 consecutive cycles, in issue order.
//  5. MUL A=16'd300 B=16'd200 (ALU_MUL_EN) -> in_ready low 17 clks, then q=16'hEA60 (60000).
//     Without the macro -> q=0, err=1 after 1 clk.
//  6. Op 4'hC -> q=0, err=1.
//     Assert rst_n=0 mid-MUL -> out_valid=0 immediately, no result emitted after release; the next ADD works normally.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for the registered ALU: opcodes, flag bundle, control FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ZERO  = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_PASSA = 4'd3,
    OP_XOR   = 4'd4,
    OP_OR    = 4'd5,
    OP_AND   = 4'd6,
    OP_INC   = 4'd7,
    OP_MUL   = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between control unit, ALU and write-back.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand side and the result side.
interface alu_pipe_if #(parameter int WIDTH = 16);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  alu_flags_t       out_flags;
  logic             out_err;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_q, out_flags, out_err
  );

  // The ALU itself
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_q, out_flags, out_err
  );

endinterface

// File: rtl/alu_pipe_mul_seq.sv
// Shift-add multiplier returning the low WIDTH bits of a*b, one partial product per clock.
// Latency: WIDTH clocks after i_start; o_done is high in the cycle of the final iteration.
// Backpressure: none; o_p holds the product until the next i_start.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  // o_done flags the edge that retires the last bit, so the product is final right after it
  assign o_done = r_busy && (r_cnt == CW'(1));
  assign o_p    = r_acc;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with {V,C,N,Z} flags and illegal-op reporting; MUL only when ALU_MUL_EN is defined.
// Latency: 1 clock for single-cycle ops, WIDTH+1 clocks for MUL; 1 beat/clk with out_ready held high.
// Backpressure: result held stable while out_valid && !out_ready; in_ready drops until the slot frees.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_q;
  alu_flags_t       r_out_flags;
  logic             r_out_err;

  logic             w_out_free;
  logic             w_accept;
  logic             w_load_alu;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH:0]   w_sum;
  alu_flags_t       w_flags;
  logic             w_err;

  // The output slot is free when empty or being drained this cycle
  assign w_out_free   = !r_out_valid || bus.out_ready;
  assign bus.in_ready = (r_state == IDLE) && w_out_free;
  assign w_accept     = bus.in_valid && bus.in_ready;

  assign bus.out_valid = r_out_valid;
  assign bus.out_q     = r_out_q;
  assign bus.out_flags = r_out_flags;
  assign bus.out_err   = r_out_err;

`ifdef ALU_MUL_EN
  logic             w_is_mul;
  logic             w_mul_done;
  logic             w_load_mul;
  logic [WIDTH-1:0] w_prod;

  assign w_is_mul   = (bus.in_op == OP_MUL);
  assign w_load_alu = w_accept && !w_is_mul;
  assign w_load_mul = (r_state == MUL_DONE) && w_out_free;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_mul),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .o_done  (w_mul_done),
    .o_p     (w_prod)
  );
`else
  assign w_load_alu = w_accept;
`endif

  // Single-cycle datapath and flag generation; unknown opcodes yield q=0, flags=0, err=1
  always_comb begin
    w_q     = '0;
    w_sum   = '0;
    w_flags = '0;
    w_err   = 1'b0;
    case (bus.in_op)
      OP_ZERO:  w_q = '0;
      OP_ADD: begin
        w_sum     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        w_q       = w_sum[WIDTH-1:0];
        w_flags.c = w_sum[WIDTH];
        w_flags.v = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) && (w_q[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow
        w_sum     = {1'b0, bus.in_a} - {1'b0, bus.in_b};
        w_q       = w_sum[WIDTH-1:0];
        w_flags.c = w_sum[WIDTH];
        w_flags.v = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) && (w_q[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OP_PASSA: w_q = bus.in_a;
      OP_XOR:   w_q = bus.in_a ^ bus.in_b;
      OP_OR:    w_q = bus.in_a | bus.in_b;
      OP_AND:   w_q = bus.in_a & bus.in_b;
      OP_INC: begin
        w_sum     = {1'b0, bus.in_a} + (WIDTH+1)'(1);
        w_q       = w_sum[WIDTH-1:0];
        w_flags.c = w_sum[WIDTH];
        w_flags.v = !bus.in_a[WIDTH-1] && w_q[WIDTH-1];
      end
`ifdef ALU_MUL_EN
      OP_MUL:   w_q = '0;  // result comes from the multiplier, never loaded from here
`endif
      default:  w_err = 1'b1;
    endcase
    if (!w_err) begin
      w_flags.z = (w_q == '0);
      w_flags.n = w_q[WIDTH-1];
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: wait out the multiplier, then wait for a free output slot
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef ALU_MUL_EN
      IDLE:     if (w_accept && w_is_mul) w_state_nxt = MUL_BUSY;
      MUL_BUSY: if (w_mul_done)           w_state_nxt = MUL_DONE;
      MUL_DONE: if (w_out_free)           w_state_nxt = IDLE;
`endif
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Output register: load a new result, otherwise drop valid once the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_flags <= '0;
      r_out_err   <= 1'b0;
    end else if (w_load_alu) begin
      r_out_valid <= 1'b1;
      r_out_q     <= w_q;
      r_out_flags <= w_flags;
      r_out_err   <= w_err;
    end
`ifdef ALU_MUL_EN
    else if (w_load_mul) begin
      r_out_valid <= 1'b1;
      r_out_q     <= w_prod;
      r_out_flags <= {2'b00, w_prod[WIDTH-1], (w_prod == '0)};
      r_out_err   <= 1'b0;
    end
`endif
    else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
